// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction and waits for commit.
// Optional perf counters enabled by defining YSYX_23060061_IFU_PERF_EN.
module ysyx_23060061_ifu #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            commit_valid,
  input  logic            commit_pcsel,
  input  logic [XLEN-1:0] commit_target,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT_RSP,
    S_HOLD,
    S_WAIT_COMMIT,
    S_FAULT
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic [XLEN-1:0] r_fault_pc;
  logic            r_req_valid;
  logic            r_inst_valid;
  logic            r_fault;

  logic [XLEN-1:0] w_next_pc;
  logic            w_next_misaligned;

  // Target bits [1:0] are deliberately not masked so misaligned redirects are caught.
  assign w_next_pc         = commit_pcsel ? commit_target : r_pc + XLEN'(4);
  assign w_next_misaligned = (w_next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_fault_pc   <= '0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          // Valid comes up one edge after reset release and stays until accepted.
          if (r_req_valid && mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT_RSP;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              r_fault    <= 1'b1;
              r_fault_pc <= r_pc;
              r_state    <= S_FAULT;
            end else begin
              r_inst       <= mem_rsp_data;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_WAIT_COMMIT;
          end
        end
        S_WAIT_COMMIT: begin
          if (commit_valid) begin
            if (w_next_misaligned) begin
              r_fault    <= 1'b1;
              r_fault_pc <= w_next_pc;
              r_state    <= S_FAULT;
            end else begin
              r_pc        <= w_next_pc;
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
        default: r_state <= S_FAULT;
      endcase
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_pc;
  assign inst_valid    = r_inst_valid;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign fault         = r_fault;
  assign fault_pc      = r_fault_pc;

`ifdef YSYX_23060061_IFU_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Free-running wrapping counters of fetched words and memory-side stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state == S_WAIT_RSP && mem_rsp_valid && !mem_rsp_err)
        r_fetch_cnt <= r_fetch_cnt + 32'(1);
      if ((r_state == S_REQ && !mem_req_ready) || (r_state == S_WAIT_RSP && !mem_rsp_valid))
        r_stall_cnt <= r_stall_cnt + 32'(1);
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && commit_valid && r_state != S_WAIT_COMMIT)
      $error("ifu: commit_valid asserted while not waiting for commit");
  end
`endif

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Self-checking bench for ysyx_23060061_ifu: directed scenarios plus random traffic against a transaction-level model.
module tb_ysyx_23060061_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit_valid;
  logic        commit_pcsel;
  logic [31:0] commit_target;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  ysyx_23060061_ifu dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .commit_valid(commit_valid), .commit_pcsel(commit_pcsel), .commit_target(commit_target),
    .fault(fault), .fault_pc(fault_pc), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  // Model phases of one instruction's life: fetching, awaiting data, presenting, executing, dead.
  localparam int M_FETCH = 0, M_AWAIT = 1, M_PRESENT = 2, M_EXEC = 3, M_DEAD = 4;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_mode;
  logic        m_req, m_inst_v, m_fault;
  logic [31:0] m_pc, m_inst, m_inst_pc, m_fault_pc, m_fcnt, m_scnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_FETCH; m_pc = 32'h8000_0000; m_req = 1'b0; m_inst_v = 1'b0;
    m_inst = '0; m_inst_pc = '0; m_fault = 1'b0; m_fault_pc = '0; m_fcnt = '0; m_scnt = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] nxt;
    case (m_mode)
      M_FETCH: begin
        if (!mem_req_ready) m_scnt = m_scnt + 1;
        if (!m_req) m_req = 1'b1;
        else if (mem_req_ready) begin m_req = 1'b0; m_mode = M_AWAIT; end
      end
      M_AWAIT: begin
        if (!mem_rsp_valid) m_scnt = m_scnt + 1;
        else if (mem_rsp_err) begin m_fault = 1'b1; m_fault_pc = m_pc; m_mode = M_DEAD; end
        else begin
          m_inst = mem_rsp_data; m_inst_pc = m_pc; m_inst_v = 1'b1;
          m_fcnt = m_fcnt + 1; m_mode = M_PRESENT;
        end
      end
      M_PRESENT: if (inst_ready) begin m_inst_v = 1'b0; m_mode = M_EXEC; end
      M_EXEC: begin
        if (commit_valid) begin
          nxt = commit_pcsel ? commit_target : m_pc + 32'd4;
          if (nxt % 4 != 0) begin m_fault = 1'b1; m_fault_pc = nxt; m_mode = M_DEAD; end
          else begin m_pc = nxt; m_req = 1'b1; m_mode = M_FETCH; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("req_valid", 32'(mem_req_valid), 32'(m_req));
    if (m_req) chk("req_addr", mem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_inst_v));
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_inst_pc);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fault_pc);
`ifdef YSYX_23060061_IFU_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fcnt);
    chk("stall_cnt", stall_cnt, m_scnt);
`else
    chk("fetch_cnt", fetch_cnt, 32'd0);
    chk("stall_cnt", stall_cnt, 32'd0);
`endif
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rd, input logic re,
                       input logic ir, input logic cv, input logic cs, input logic [31:0] ct);
    mem_req_ready = rdy; mem_rsp_valid = rv; mem_rsp_data = rd; mem_rsp_err = re;
    inst_ready = ir; commit_valid = cv; commit_pcsel = cs; commit_target = ct;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    inst_ready = 1'b0; commit_valid = 1'b0; commit_pcsel = 1'b0; commit_target = '0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  task automatic run_fetch(input logic [31:0] data, input int req_stall, input int rsp_dly,
                           input int hold_stall, input logic err);
    int guard = 0;
    int stalls = 0;
    while (m_mode == M_FETCH && guard < 50) begin
      if (m_req && stalls < req_stall) begin
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        stalls++;
      end else begin
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      end
      guard++;
    end
    if (guard >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL fetch_timeout: request not accepted within %0d cycles", guard);
    end
    for (int i = 0; i < rsp_dly; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, data, err, 1'b0, 1'b0, 1'b0, '0);
    if (!err) begin
      for (int i = 0; i < hold_stall; i++) begin
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("hold_inst_stable", inst, data);
      end
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic run_commit(input logic sel, input logic [31:0] tgt);
    if (m_mode == M_EXEC) begin
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, sel, tgt);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL commit_phase: model phase %0d is not awaiting commit", m_mode);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rdy, rv, re, ir, cv, cs;
    logic [31:0] rd, ct, t;
    int          r;

    rst = 1'b1;
    model_reset();
    @(negedge clk);

    // First fetch: accept, one-cycle memory, inst_valid two cycles after accept.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("first_req_valid", 32'(mem_req_valid), 32'd1);
    chk("first_req_addr", mem_req_addr, 32'h8000_0000);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("accept_drops_valid", 32'(mem_req_valid), 32'd0);
    chk("inst_valid_not_yet", 32'(inst_valid), 32'd0);
    cycle(1'b1, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("first_inst_valid", 32'(inst_valid), 32'd1);
    chk("first_inst", inst, 32'h0010_0093);
    chk("first_inst_pc", inst_pc, 32'h8000_0000);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("inst_valid_drops", 32'(inst_valid), 32'd0);
    chk("inst_holds", inst, 32'h0010_0093);
    run_commit(1'b0, 32'h1234_5678);
    chk("seq_req_valid", 32'(mem_req_valid), 32'd1);
    chk("seq_addr", mem_req_addr, 32'h8000_0004);
    run_fetch(32'h0020_0113, 3, 0, 2, 1'b0);
    chk("stalled_fetch_pc", inst_pc, 32'h8000_0004);
`ifdef YSYX_23060061_IFU_PERF_EN
    chk("stall_cnt_three", stall_cnt, 32'd3);
    chk("fetch_cnt_two", fetch_cnt, 32'd2);
`endif
    run_commit(1'b1, 32'h8000_0100);
    chk("jump_addr", mem_req_addr, 32'h8000_0100);
    run_fetch($urandom, 0, 1, 0, 1'b0);
    run_commit(1'b1, 32'h8000_0102);
    chk("misalign_fault", 32'(fault), 32'd1);
    chk("misalign_fault_pc", fault_pc, 32'h8000_0102);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("fault_no_req", 32'(mem_req_valid), 32'd0);
    end

    // Access fault on the third fetch.
    do_reset();
    run_fetch($urandom, 0, 0, 0, 1'b0);
    run_commit(1'b0, '0);
    run_fetch($urandom, 1, 2, 1, 1'b0);
    run_commit(1'b0, '0);
    run_fetch(32'hDEAD_BEEF, 0, 0, 0, 1'b1);
    chk("err_fault", 32'(fault), 32'd1);
    chk("err_fault_pc", fault_pc, 32'h8000_0008);
    chk("err_no_inst_valid", 32'(inst_valid), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // PC wraps from the top of the address space without faulting.
    do_reset();
    run_fetch($urandom, 0, 0, 0, 1'b0);
    run_commit(1'b1, 32'hFFFF_FFFC);
    chk("top_addr", mem_req_addr, 32'hFFFF_FFFC);
    run_fetch($urandom, 0, 0, 0, 1'b0);
    run_commit(1'b0, '0);
    chk("wrap_addr", mem_req_addr, 32'h0000_0000);
    chk("wrap_no_fault", 32'(fault), 32'd0);

    // Reset while waiting for a response; a stale response afterwards is dropped.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    do_reset();
    cycle(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("post_rst_addr", mem_req_addr, 32'h8000_0000);
    chk("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    cycle(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("stale_rsp_dropped", 32'(inst_valid), 32'd0);

    // Random traffic, including spurious responses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ((m_mode == M_DEAD && $urandom_range(3) == 0) || $urandom_range(399) == 0) begin
        do_reset();
      end else begin
        rdy = ($urandom_range(2) != 0);
        rv  = (m_mode == M_AWAIT) ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
        rd  = $urandom;
        re  = ($urandom_range(29) == 0);
        ir  = $urandom_range(1) == 1;
        cv  = (m_mode == M_EXEC) && ($urandom_range(2) == 0);
        cs  = $urandom_range(1) == 1;
        r   = $urandom_range(15);
        t   = $urandom;
        if (r == 0)      ct = 32'hFFFF_FFFC;
        else if (r == 1) ct = t | 32'd1;
        else if (r == 2) ct = (t & ~32'd3) | 32'd2;
        else             ct = t & ~32'd3;
        cycle(rdy, rv, rd, re, ir, cv, cs, ct);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_ifu.md
Name: ysyx_23060061_ifu

Overview:
- Instruction fetch unit for the multicycle NPC core; it is the producer end of the instruction path that the decoder consumes.
- Owns the architectural PC and issues word reads to instruction memory over a valid/ready request + valid response interface.
- Presents each fetched instruction and its PC to the decode stage with a valid/ready handshake.
- Waits for the execute stage's commit (PCSel + target) before fetching the next instruction.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, PC/address/instruction width; only 32 supported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  fetch address (word aligned).
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  instruction word.
- mem_rsp_err  in  1  access fault, qualified by mem_rsp_valid.
- inst_valid  out  1  instruction available to decoder.
- inst_ready  in  1  decoder accepts instruction.
- inst  out  XLEN  instruction word.
- inst_pc  out  XLEN  PC of inst.
- commit_valid  in  1  current instruction finished execute/writeback.
- commit_pcsel  in  1  1 = take commit_target, 0 = PC+4.
- commit_target  in  XLEN  redirect target (jal/jalr/taken branch).
- fault  out  1  sticky fetch fault.
- fault_pc  out  XLEN  PC causing the fault.
- fetch_cnt  out  32  perf counter (see Optional Feature).
- stall_cnt  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset state (async, while rst=1): state=REQ, pc=RESET_PC.
- Output reset values: mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, fault=0, fault_pc=0, counters=0.
- The first request is asserted on the first clk edge after rst deasserts.
- FSM states:
  - REQ: mem_req_valid=1, mem_req_addr=pc.
    - addr and valid are held stable until mem_req_ready=1.
    - On accept -> WAIT_RSP.
  - WAIT_RSP: mem_req_valid=0.
    - mem_rsp_valid is sampled only here; a response in the accept cycle itself is ignored by protocol.
    - On mem_rsp_valid&!mem_rsp_err: latch inst=mem_rsp_data, inst_pc=pc -> HOLD.
    - On mem_rsp_valid&mem_rsp_err -> FAULT with fault_pc=pc.
  - HOLD: inst_valid=1; inst and inst_pc are stable while waiting.
    - On inst_valid&inst_ready -> WAIT_COMMIT; inst_valid drops next cycle.
  - WAIT_COMMIT: inst/inst_pc hold their last values; inst_valid=0.
    - On commit_valid: next=commit_pcsel ? commit_target : pc+4.
    - If next[1:0]!=0 -> FAULT with fault_pc=next.
    - Otherwise pc<=next -> REQ.
  - FAULT: all handshake outputs 0, fault=1. The state is terminal until rst.
- Minimum latency: request-accept to inst_valid is 2 cycles with a 1-cycle memory; commit to the next mem_req_valid is 1 cycle.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000 with no fault. commit_target bits [1:0] are not masked; alignment is checked.
- commit_valid outside WAIT_COMMIT is ignored and flagged by a simulation-only $error.
- mem_rsp_valid outside WAIT_RSP is ignored.
- Reset asserted mid-transaction aborts immediately. Any in-flight response after reset is dropped because the FSM is in REQ.
- inst_ready with inst_valid=0 has no effect.

Optional Feature:
- Macro: YSYX_23060061_IFU_PERF_EN.
- Defined:
  - fetch_cnt increments on each successful response latch.
  - stall_cnt increments each cycle in REQ with mem_req_ready=0, or in WAIT_RSP with mem_rsp_valid=0.
  - Both counters are 32-bit, wrap, and reset to 0.
- Undefined: fetch_cnt and stall_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle memory returning 32'h0010_0093 -> mem_req_addr=32'h8000_0000; inst_valid rises 2 cycles after accept with inst=32'h0010_0093 and inst_pc=32'h8000_0000.
- mem_req_ready low 3 cycles, then inst_ready low 2 cycles -> mem_req_addr stable through the stall; inst/inst_pc stable through backpressure; with PERF_EN, stall_cnt=3.
- Commit with commit_pcsel=0 at pc=32'h8000_0000 -> next request addr 32'h8000_0004. Commit with commit_pcsel=1, target=32'h8000_0100 -> addr 32'h8000_0100.
- Commit with pcsel=1, target=32'h8000_0102 -> fault=1, fault_pc=32'h8000_0102, no further mem_req_valid until rst.
- mem_rsp_err=1 at pc=32'h8000_0008 -> fault=1, fault_pc=32'h8000_0008, inst_valid stays 0.
- pc=32'hFFFF_FFFC with pcsel=0 commit -> addr 32'h0000_0000, no fault. Separately, rst pulsed during WAIT_RSP -> outputs return to reset values at once and the next request goes to RESET_PC.
